// File: rtl/fht_but_core.sv
// rtl/fht_but_core.sv - radix-2 two-dot FHT butterfly, two-stage pipeline
//
// Purpose:
//   Rotates (iX_1, iX_2) by the twiddle pair (iCOS, iSIN), then adds the
//   rotation to iX_0 and subtracts it from iX_0. The result is halved so the
//   stage does not grow. One butterfly is accepted per clock. There is no
//   handshake and no stall.
//
// Pipeline:
//   edge k   : P  = iCOS*iX_1 + iSIN*iX_2   (full precision, D+W+1 bits)
//   edge k+1 : R  = P / 2U                  (U = 2^(W_SIZE-2))
//              oY_0 = (iX_0 + R) / 2,  oY_1 = (iX_0 - R) / 2
//   iX_0 is therefore presented one cycle after the iX_1/iX_2/iSIN/iCOS
//   values it pairs with.
//
// Ports:
//   iCLK    in   1        clock, rising edge
//   iRESET  in   1        asynchronous reset, active low
//   iX_0    in   D_SIZE   signed sample, added/subtracted directly
//   iX_1    in   D_SIZE   signed sample, multiplied by iCOS
//   iX_2    in   D_SIZE   signed sample, multiplied by iSIN
//   iSIN    in   W_SIZE   signed twiddle sine,   -U..+U
//   iCOS    in   W_SIZE   signed twiddle cosine, -U..+U
//   oY_0    out  D_SIZE   registered sum output
//   oY_1    out  D_SIZE   registered difference output
//
// Build option:
//   FHT_BUT_ROUND_EN  defined   -> both divisions round to nearest, half up
//                     undefined -> both divisions truncate toward -infinity

module fht_but_core #(
  parameter int D_SIZE = 16,
  parameter int W_SIZE = 16
) (
  input  logic                     iCLK,
  input  logic                     iRESET,
  input  logic signed [D_SIZE-1:0] iX_0,
  input  logic signed [D_SIZE-1:0] iX_1,
  input  logic signed [D_SIZE-1:0] iX_2,
  input  logic signed [W_SIZE-1:0] iSIN,
  input  logic signed [W_SIZE-1:0] iCOS,
  output logic signed [D_SIZE-1:0] oY_0,
  output logic signed [D_SIZE-1:0] oY_1
);

  localparam int PW = D_SIZE + W_SIZE;  // single product width
  localparam int SW = PW + 1;           // sum of two products

  // ---------------------------------------------------------------------------
  // Stage 1: rotation products, kept at full precision
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] x1_ext;
  logic signed [PW-1:0] x2_ext;
  logic signed [PW-1:0] cos_ext;
  logic signed [PW-1:0] sin_ext;
  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] prod_s;
  logic signed [SW-1:0] p_next;
  logic signed [SW-1:0] p_reg;

  // Operands are sign-extended to the product width up front so the multiply
  // is a same-width signed multiply whose low PW bits are the exact product.
  assign x1_ext  = {{W_SIZE{iX_1[D_SIZE-1]}}, iX_1};
  assign x2_ext  = {{W_SIZE{iX_2[D_SIZE-1]}}, iX_2};
  assign cos_ext = {{D_SIZE{iCOS[W_SIZE-1]}}, iCOS};
  assign sin_ext = {{D_SIZE{iSIN[W_SIZE-1]}}, iSIN};

  assign prod_c = cos_ext * x1_ext;
  assign prod_s = sin_ext * x2_ext;
  assign p_next = {prod_c[PW-1], prod_c} + {prod_s[PW-1], prod_s};

  // ---------------------------------------------------------------------------
  // Stage 2: scale the rotation by 1/(2U), then butterfly and halve
  // ---------------------------------------------------------------------------
  logic signed [D_SIZE-1:0] r_val;
  logic signed [D_SIZE-1:0] y0_next;
  logic signed [D_SIZE-1:0] y1_next;
  logic                     unused_bits;

`ifdef FHT_BUT_ROUND_EN
  // One extra bit on every rounding adder so that adding the half-LSB
  // constant to the most positive operand cannot wrap.
  localparam int RW = SW + 1;
  localparam logic [RW-1:0] P_HALF = RW'(1) << (W_SIZE - 2);

  logic signed [RW-1:0]     p_rnd;
  logic signed [RW-1:0]     p_shift;
  logic        [D_SIZE+1:0] sum_a;
  logic        [D_SIZE+1:0] sum_s;

  assign p_rnd   = {p_reg[SW-1], p_reg} + P_HALF;
  assign p_shift = p_rnd >>> (W_SIZE - 1);
  // For legal coefficients |R| <= 0.71*MAX_D, so the low D_SIZE bits hold R.
  assign r_val   = p_shift[D_SIZE-1:0];

  assign sum_a = {{2{iX_0[D_SIZE-1]}}, iX_0} + {{2{r_val[D_SIZE-1]}}, r_val}
                 + (D_SIZE+2)'(1);
  assign sum_s = {{2{iX_0[D_SIZE-1]}}, iX_0} - {{2{r_val[D_SIZE-1]}}, r_val}
                 + (D_SIZE+2)'(1);

  // Taking bits [D_SIZE:1] is the arithmetic >>1; the result always fits.
  assign y0_next = sum_a[D_SIZE:1];
  assign y1_next = sum_s[D_SIZE:1];

  // Bits outside the output range are sign copies for legal inputs.
  assign unused_bits = ^{p_shift[RW-1:D_SIZE], sum_a[D_SIZE+1], sum_a[0],
                         sum_s[D_SIZE+1], sum_s[0]};
`else
  logic signed [SW-1:0]     p_shift;
  logic        [D_SIZE:0]   sum_a;
  logic        [D_SIZE:0]   sum_s;

  // Arithmetic shift: truncation toward minus infinity.
  assign p_shift = p_reg >>> (W_SIZE - 1);
  // For legal coefficients |R| <= 0.71*MAX_D, so the low D_SIZE bits hold R.
  assign r_val   = p_shift[D_SIZE-1:0];

  // Add/subtract at D_SIZE+1 bits, then drop the LSB for the >>1.
  assign sum_a = {iX_0[D_SIZE-1], iX_0} + {r_val[D_SIZE-1], r_val};
  assign sum_s = {iX_0[D_SIZE-1], iX_0} - {r_val[D_SIZE-1], r_val};

  assign y0_next = sum_a[D_SIZE:1];
  assign y1_next = sum_s[D_SIZE:1];

  // Bits outside the output range are sign copies for legal inputs.
  assign unused_bits = ^{p_shift[SW-1:D_SIZE], sum_a[0], sum_s[0]};
`endif

  // ---------------------------------------------------------------------------
  // Pipeline registers; reset discards any butterfly in flight
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      p_reg <= '0;
      oY_0  <= '0;
      oY_1  <= '0;
    end else begin
      p_reg <= p_next;
      oY_0  <= y0_next;
      oY_1  <= y1_next;
    end
  end

endmodule

// File: tb/tb_fht_but_core.sv
// tb/tb_fht_but_core.sv - self-checking random/directed bench for fht_but_core

module tb_fht_but_core;

  localparam int D_SIZE = 16;
  localparam int W_SIZE = 16;
  localparam int U      = 16384;
  localparam int MAXP   = 32767;
  localparam int MAXN   = -32768;

  logic                     iCLK = 1'b0;
  logic                     iRESET = 1'b0;
  logic signed [D_SIZE-1:0] iX_0 = '0;
  logic signed [D_SIZE-1:0] iX_1 = '0;
  logic signed [D_SIZE-1:0] iX_2 = '0;
  logic signed [W_SIZE-1:0] iSIN = '0;
  logic signed [W_SIZE-1:0] iCOS = '0;
  logic signed [D_SIZE-1:0] oY_0;
  logic signed [D_SIZE-1:0] oY_1;

  fht_but_core #(.D_SIZE(D_SIZE), .W_SIZE(W_SIZE)) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .iX_0   (iX_0),
    .iX_1   (iX_1),
    .iX_2   (iX_2),
    .iSIN   (iSIN),
    .iCOS   (iCOS),
    .oY_0   (oY_0),
    .oY_1   (oY_1)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int x0;
    int x1;
    int x2;
    int c;
    int s;
    bit lit;
    int e0;
    int e1;
  } txn_t;

  txn_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint r;
    r = a / b;
    if ((a % b) != 0 && a < 0) r = r - 1;
    return r;
  endfunction

  // Reference: exact rational rotation divided by 2U, then halved, with the
  // division rule chosen by the build option.
  task automatic model(input txn_t t, output int y0, output int y1);
    longint p, r;
    p = longint'(t.c) * t.x1 + longint'(t.s) * t.x2;
`ifdef FHT_BUT_ROUND_EN
    r  = fdiv(p + U, 2 * U);
    y0 = int'(fdiv(t.x0 + r + 1, 2));
    y1 = int'(fdiv(t.x0 - r + 1, 2));
`else
    r  = fdiv(p, 2 * U);
    y0 = int'(fdiv(t.x0 + r, 2));
    y1 = int'(fdiv(t.x0 - r, 2));
`endif
  endtask

  task automatic check_txn(input txn_t t, input int idx);
    int  y0, y1, g0, g1;
    real rot, id0, id1, e0, e1, lim;
    model(t, y0, y1);
    g0 = int'(oY_0);
    g1 = int'(oY_1);
    check($sformatf("y0[%0d]", idx), g0, y0);
    check($sformatf("y1[%0d]", idx), g1, y1);
    rot = (real'(t.c) * t.x1 + real'(t.s) * t.x2) / (2.0 * U);
    id0 = (real'(t.x0) + rot) / 2.0;
    id1 = (real'(t.x0) - rot) / 2.0;
    e0  = (g0 > id0) ? (g0 - id0) : (id0 - g0);
    e1  = (g1 > id1) ? (g1 - id1) : (id1 - g1);
`ifdef FHT_BUT_ROUND_EN
    lim = 0.75;
`else
    lim = 0.999999;
`endif
    check($sformatf("acc0[%0d]", idx), longint'(e0 <= lim), 1);
    check($sformatf("acc1[%0d]", idx), longint'(e1 <= lim), 1);
    if (t.lit) begin
      check($sformatf("lit0[%0d]", idx), g0, t.e0);
      check($sformatf("lit1[%0d]", idx), g1, t.e1);
    end
  endtask

  // Streams the queue back to back: coefficients of txn t and x0 of txn t-1
  // are driven in the same cycle; txn t-2 is visible on the outputs.
  task automatic run_stream();
    int n;
    n = q.size();
    for (int t = 0; t < n + 2; t++) begin
      @(negedge iCLK);
      if (t >= 2) check_txn(q[t-2], t - 2);
      if (t < n) begin
        iX_1 = 16'(q[t].x1);
        iX_2 = 16'(q[t].x2);
        iCOS = 16'(q[t].c);
        iSIN = 16'(q[t].s);
      end else begin
        iX_1 = '0;
        iX_2 = '0;
        iCOS = '0;
        iSIN = '0;
      end
      if (t >= 1 && t <= n) iX_0 = 16'(q[t-1].x0);
      else iX_0 = '0;
    end
    q.delete();
  endtask

  function automatic int rnd_d();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic drive_random();
    iX_0 = 16'(rnd_d());
    iX_1 = 16'(rnd_d());
    iX_2 = 16'(rnd_d());
    iCOS = 16'(rnd_d());
    iSIN = 16'(rnd_d());
  endtask

  task automatic push(input int x0, input int x1, input int x2, input int c,
                      input int s, input bit lit, input int e0, input int e1);
    txn_t t;
    t.x0 = x0; t.x1 = x1; t.x2 = x2; t.c = c; t.s = s;
    t.lit = lit; t.e0 = e0; t.e1 = e1;
    q.push_back(t);
  endtask

  int ang_c[8] = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
  int ang_s[8] = '{0, 11585, 16384, 11585, 0, -11585, -16384, -11585};

  initial begin
    int s, c, x0, x1, x2;

    // Reset held with random inputs
    iRESET = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_random();
      @(negedge iCLK);
      check($sformatf("rst_y0[%0d]", i), oY_0, 0);
      check($sformatf("rst_y1[%0d]", i), oY_1, 0);
    end
    iRESET = 1'b1;
    iX_0 = '0; iX_1 = '0; iX_2 = '0; iCOS = '0; iSIN = '0;
    @(negedge iCLK);
    check("post_rst_y0", oY_0, 0);
    check("post_rst_y1", oY_1, 0);

    // Directed angles with known results
    push(2000, 1000, 0, 16384, 0, 1'b1, 1250, 750);
    push(MAXP, MAXP, MAXP, 11585, 11585, 1'b1, 27968, 4799);
    push(MAXN, MAXN, MAXN, -11585, -11585, 1'b1, -4799, -27969);

    // Special angles x full-scale sign combinations
    for (int a = 0; a < 8; a++) begin
      for (int m = 0; m < 8; m++) begin
        push(m[0] ? MAXN : MAXP, m[1] ? MAXN : MAXP, m[2] ? MAXN : MAXP,
             ang_c[a], ang_s[a], 1'b0, 0, 0);
      end
    end
    run_stream();

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      drive_random();
    end
    @(posedge iCLK);
    #2 iRESET = 1'b0;
    #1;
    check("mid_rst_y0", oY_0, 0);
    check("mid_rst_y1", oY_1, 0);
    @(negedge iCLK);
    check("mid_rst_hold_y0", oY_0, 0);
    check("mid_rst_hold_y1", oY_1, 0);
    iRESET = 1'b1;
    iX_0 = '0; iX_1 = '0; iX_2 = '0; iCOS = '0; iSIN = '0;
    @(negedge iCLK);
    check("mid_rel_y0", oY_0, 0);
    check("mid_rel_y1", oY_1, 0);

    // Random unit-magnitude twiddles, back to back
    for (int i = 0; i < 10000; i++) begin
      s = int'($urandom_range(2 * U)) - U;
      c = int'($floor($sqrt(real'(U * U - s * s))));
      while (c * c + s * s > U * U) c = c - 1;
      if ($urandom_range(1) == 1) c = -c;
      x0 = rnd_d();
      x1 = rnd_d();
      x2 = rnd_d();
      push(x0, x1, x2, c, s, 1'b0, 0, 0);
    end
    run_stream();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
